// File: rtl/elevator_pkg.sv
// Shared elevator encodings: controller state and travel direction.
// The VGA controller decodes sim_state with the same enum.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    DOOR = 2'b11
  } sim_state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/floor_scan.sv
// Finds whether requests exist above/below a floor and the
// nearest requested floor on each side.
module floor_scan #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 8
) (
  input  logic [NUM_FLOORS-1:0] mask,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  above,
  output logic                  below,
  output logic [FLOOR_W-1:0]    near_above,
  output logic [FLOOR_W-1:0]    near_below
);

  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    near_above = cur_floor;
    near_below = cur_floor;
    // walk downward so the last hit is the lowest floor above
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (mask[i] && (FLOOR_W'(i) > cur_floor)) begin
        above      = 1'b1;
        near_above = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (mask[i] && (FLOOR_W'(i) < cur_floor)) begin
        below      = 1'b1;
        near_below = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator controller: latches floor requests, moves one
// floor per TRAVEL_TICKS ticks, holds doors for DOOR_TICKS ticks.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 8,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    destination,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            sim_state,
  output logic                  door_open
);

  localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  sim_state_t            state, state_n;
  dir_t                  dir, dir_n;
  logic [FLOOR_W-1:0]    cur, cur_n, nxt;
  logic [NUM_FLOORS-1:0] pend, pend_n, mask;
  logic [NUM_FLOORS-1:0] here_v, arr_v;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [DW-1:0]         dcnt, dcnt_n;
  logic                  above, below, p_above, p_below;
  logic                  go_same, go_rev;
  logic [FLOOR_W-1:0]    unused_a, unused_b, p_near_a, p_near_b;

  assign mask = pend | req;

  floor_scan #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_scan (
    .mask      (mask),
    .cur_floor (cur),
    .above     (above),
    .below     (below),
    .near_above(unused_a),
    .near_below(unused_b)
  );

  // display target follows registered state only
  floor_scan #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_dest (
    .mask      (pend),
    .cur_floor (cur),
    .above     (p_above),
    .below     (p_below),
    .near_above(p_near_a),
    .near_below(p_near_b)
  );

  always_comb begin
    nxt = cur;
    if (state == UP && cur != TOP) nxt = cur + FLOOR_W'(1);
    if (state == DOWN && cur != '0) nxt = cur - FLOOR_W'(1);
    here_v  = mask >> cur;
    arr_v   = mask >> nxt;
    go_same = (dir == DIR_UP) ? above : below;
    go_rev  = (dir == DIR_UP) ? below : above;
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    cur_n   = cur;
    pend_n  = mask;
    tcnt_n  = tcnt;
    dcnt_n  = dcnt;
    unique case (state)
      IDLE: begin
        if (here_v[0]) begin
          state_n = DOOR;
          pend_n  = mask & ~(ONE << cur);
          dcnt_n  = '0;
        end else if (above && (dir == DIR_UP || !below)) begin
          state_n = UP;
          dir_n   = DIR_UP;
          tcnt_n  = '0;
        end else if (below) begin
          state_n = DOWN;
          dir_n   = DIR_DN;
          tcnt_n  = '0;
        end
      end
      UP, DOWN: begin
        if (!go_same) begin
          state_n = IDLE;
        end else if (tick) begin
          if (tcnt == T_LAST) begin
            tcnt_n = '0;
            cur_n  = nxt;
            if (arr_v[0]) begin
              state_n = DOOR;
              pend_n  = mask & ~(ONE << nxt);
              dcnt_n  = '0;
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      DOOR: begin
        if (here_v[0]) begin
          pend_n = mask & ~(ONE << cur);
          dcnt_n = '0;
        end else if (tick) begin
          if (dcnt == D_LAST) begin
            dcnt_n = '0;
            tcnt_n = '0;
            if (go_same) begin
              if (dir == DIR_UP) state_n = UP;
              else state_n = DOWN;
            end else if (go_rev) begin
              if (dir == DIR_UP) begin
                state_n = DOWN;
                dir_n   = DIR_DN;
              end else begin
                state_n = UP;
                dir_n   = DIR_UP;
              end
            end else begin
              state_n = IDLE;
            end
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dir   <= DIR_UP;
      cur   <= '0;
      pend  <= '0;
      tcnt  <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      cur   <= cur_n;
      pend  <= pend_n;
      tcnt  <= tcnt_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    destination = cur;
    if (state == UP && p_above) destination = p_near_a;
    if (state == DOWN && p_below) destination = p_near_b;
  end

  assign current_floor = cur;
  assign pending       = pend;
  assign sim_state     = state;
  assign door_open     = (state == DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scenario bench for elevator_scheduler with a stop-order scoreboard.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] req;
  logic [7:0] current_floor;
  logic [7:0] destination;
  logic [7:0] pending;
  logic [1:0] sim_state;
  logic       door_open;

  int errors = 0;
  int checks = 0;
  int sb[$];

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_UP   = 2'b01;
  localparam logic [1:0] S_DOWN = 2'b10;
  localparam logic [1:0] S_DOOR = 2'b11;

  elevator_scheduler #(
    .NUM_FLOORS  (8),
    .FLOOR_W     (8),
    .TRAVEL_TICKS(4),
    .DOOR_TICKS  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .req          (req),
    .current_floor(current_floor),
    .destination  (destination),
    .pending      (pending),
    .sim_state    (sim_state),
    .door_open    (door_open)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] m);
    req = m;
    cyc(1);
    req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic wait_cond(input logic [1:0] s, input bit eq,
                           input int budget,
                           output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      cyc(1);
      n++;
      if ((sim_state == s) == eq) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick = 1'b1;
    cyc(2);
    checks++;
    if ({current_floor, destination, pending, sim_state, door_open} !== '0) begin
      errors++;
      $display("FAIL reset_state: floor=%0d dest=%0d pend=%h st=%b door=%b want all 0",
               current_floor, destination, pending, sim_state, door_open);
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_single_trip();
    int n;
    bit ok;
    int exp;
    do_reset();
    sb.push_back(3);
    pulse(8'h08);
    checks++;
    if (sim_state !== S_UP || destination !== 8'd3 || pending !== 8'h08) begin
      errors++;
      $display("FAIL trip_start: st=%b dest=%0d pend=%h want 01/3/08",
               sim_state, destination, pending);
    end
    wait_cond(S_DOOR, 1'b1, 40, n, ok);
    checks++;
    if (!ok || n !== 12) begin
      errors++;
      $display("FAIL trip_latency: got %0d cycles ok=%0b want 12", n, ok);
    end
    exp = sb.pop_front();
    checks++;
    if (current_floor !== 8'(exp) || pending !== 8'h00) begin
      errors++;
      $display("FAIL trip_arrive: floor=%0d pend=%h want %0d/00",
               current_floor, pending, exp);
    end
    wait_cond(S_DOOR, 1'b0, 20, n, ok);
    checks++;
    if (!ok || n !== 3 || sim_state !== S_IDLE) begin
      errors++;
      $display("FAIL trip_door_close: cycles=%0d st=%b want 3/00", n, sim_state);
    end
  endtask

  task automatic test_scan_order();
    int n;
    bit ok;
    int exp;
    logic [7:0] exp_pend[3] = '{8'h22, 8'h02, 8'h00};
    logic [1:0] exp_next[3] = '{S_UP, S_DOWN, S_IDLE};
    do_reset();
    pulse(8'h20);
    cyc(5);
    checks++;
    if (current_floor !== 8'd1 || sim_state !== S_UP) begin
      errors++;
      $display("FAIL scan_midtravel: floor=%0d st=%b want 1/01",
               current_floor, sim_state);
    end
    sb.push_back(2);
    sb.push_back(5);
    sb.push_back(1);
    pulse(8'h06);
    for (int k = 0; k < 3; k++) begin
      wait_cond(S_DOOR, 1'b1, 80, n, ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || current_floor !== 8'(exp) || pending !== exp_pend[k]) begin
        errors++;
        $display("FAIL scan_stop%0d: floor=%0d pend=%h ok=%0b want %0d/%h",
                 k, current_floor, pending, ok, exp, exp_pend[k]);
      end
      wait_cond(S_DOOR, 1'b0, 20, n, ok);
      checks++;
      if (!ok || sim_state !== exp_next[k]) begin
        errors++;
        $display("FAIL scan_leave%0d: st=%b want %b", k, sim_state, exp_next[k]);
      end
    end
  endtask

  task automatic test_door_reopen();
    int n;
    bit ok;
    do_reset();
    pulse(8'h10);
    wait_cond(S_DOOR, 1'b1, 40, n, ok);
    checks++;
    if (!ok || current_floor !== 8'd4) begin
      errors++;
      $display("FAIL reopen_arrive: floor=%0d ok=%0b want 4", current_floor, ok);
    end
    cyc(2);
    pulse(8'h10);
    checks++;
    if (sim_state !== S_DOOR || pending !== 8'h00) begin
      errors++;
      $display("FAIL reopen_absorb: st=%b pend=%h want 11/00", sim_state, pending);
    end
    wait_cond(S_DOOR, 1'b0, 20, n, ok);
    checks++;
    if (!ok || n !== 3 || sim_state !== S_IDLE) begin
      errors++;
      $display("FAIL reopen_length: cycles=%0d st=%b want 3/00", n, sim_state);
    end
    pulse(8'h10);
    checks++;
    if (sim_state !== S_DOOR || pending !== 8'h00 || current_floor !== 8'd4) begin
      errors++;
      $display("FAIL idle_here: st=%b pend=%h floor=%0d want 11/00/4",
               sim_state, pending, current_floor);
    end
  endtask

  task automatic test_tick_freeze();
    do_reset();
    pulse(8'h20);
    cyc(2);
    tick = 1'b0;
    pulse(8'h80);
    cyc(19);
    checks++;
    if (current_floor !== 8'd0 || sim_state !== S_UP || pending !== 8'hA0
        || destination !== 8'd5) begin
      errors++;
      $display("FAIL freeze_hold: floor=%0d st=%b pend=%h dest=%0d want 0/01/a0/5",
               current_floor, sim_state, pending, destination);
    end
    tick = 1'b1;
    cyc(1);
    checks++;
    if (current_floor !== 8'd0) begin
      errors++;
      $display("FAIL freeze_resume1: floor=%0d want 0", current_floor);
    end
    cyc(1);
    checks++;
    if (current_floor !== 8'd1) begin
      errors++;
      $display("FAIL freeze_resume2: floor=%0d want 1", current_floor);
    end
  endtask

  task automatic test_dir_pref();
    int n;
    bit ok;
    do_reset();
    pulse(8'h20);
    wait_cond(S_DOOR, 1'b1, 40, n, ok);
    wait_cond(S_DOOR, 1'b0, 20, n, ok);
    pulse(8'h08);
    wait_cond(S_DOOR, 1'b1, 40, n, ok);
    checks++;
    if (!ok || current_floor !== 8'd3) begin
      errors++;
      $display("FAIL pref_setup: floor=%0d ok=%0b want 3", current_floor, ok);
    end
    wait_cond(S_DOOR, 1'b0, 20, n, ok);
    checks++;
    if (!ok || sim_state !== S_IDLE) begin
      errors++;
      $display("FAIL pref_idle: st=%b want 00", sim_state);
    end
    pulse(8'h42);
    checks++;
    if (sim_state !== S_DOWN || destination !== 8'd1 || pending !== 8'h42) begin
      errors++;
      $display("FAIL pref_down: st=%b dest=%0d pend=%h want 10/1/42",
               sim_state, destination, pending);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(8'h40);
    cyc(5);
    checks++;
    if (current_floor !== 8'd1 || pending !== 8'h40) begin
      errors++;
      $display("FAIL areset_setup: floor=%0d pend=%h want 1/40",
               current_floor, pending);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    req = 8'hFF;
    #1;
    checks++;
    if ({current_floor, destination, pending, sim_state, door_open} !== '0) begin
      errors++;
      $display("FAIL areset_async: floor=%0d dest=%0d pend=%h st=%b door=%b want all 0",
               current_floor, destination, pending, sim_state, door_open);
    end
    cyc(2);
    checks++;
    if (pending !== 8'h00) begin
      errors++;
      $display("FAIL areset_req_ignored: pend=%h want 00", pending);
    end
    req = '0;
    rst = 1'b0;
    cyc(3);
    checks++;
    if (sim_state !== S_IDLE || pending !== 8'h00 || current_floor !== 8'd0) begin
      errors++;
      $display("FAIL areset_after: st=%b pend=%h floor=%0d want 00/00/0",
               sim_state, pending, current_floor);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    tick = 1'b1;
    test_reset();
    test_single_trip();
    test_scan_order();
    test_door_reopen();
    test_tick_freeze();
    test_dir_pref();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
